// File: rtl/eta_lock_pkg.sv
// Shared types and constants for the locked ETA-II pipelined adder.
package eta_lock_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SEG_W = 4;
  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    KEY_EMPTY,
    KEY_LOADING,
    KEY_ARMED
  } key_state_t;

  // Number of speculative-carry segments for a given operand width.
  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/eta_segment_add.sv
// One ETA-II segment: full segment sum with carry-in, plus the carry it would
// generate on its own (carry-in 0), which feeds the next segment's speculation.
module eta_segment_add #(
  parameter int unsigned SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             gen
);

  logic [SEG_W-1:0] unused_gen_sum;

  // Segment sum with carry-in, and the standalone generate carry.
  always_comb begin
    {cout, sum}          = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
    {gen, unused_gen_sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/eta2_adder_locked_pipe.sv
// Pipelined ETA-II adder with XOR/XNOR key locking and a serially loaded key.
// Optional exact-sum checker enabled by defining ETA_EXACT_CHECK_EN.
module eta2_adder_locked_pipe
  import eta_lock_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG_W = DEF_SEG_W,
  parameter logic [WIDTH+nseg(WIDTH, SEG_W)-1:0] KEY_CORRECT = 20'hB89E0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_shift_i,
  input  logic             key_sdi_i,
  output logic             key_armed_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o
`ifdef ETA_EXACT_CHECK_EN
  ,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam int unsigned NSEG  = nseg(WIDTH, SEG_W);
  localparam int unsigned KEY_W = WIDTH + NSEG;
  localparam int unsigned CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);

  key_state_t       state;
  logic [KEY_W-1:0] key_q;
  logic [CNT_W-1:0] cnt;

  logic             armed, flush, accept, adv1, adv2;
  logic             v1, v2;
  logic [WIDTH-1:0] a_q, b_q;
  logic [NSEG-1:0]  cg_q;

  logic [NSEG-1:0]  raw_c, cg;
  logic [WIDTH-1:0] sum_raw;
  logic [NSEG-1:0]  seg_cout;
  logic [NSEG-1:0]  unused_cout;
  logic [NSEG-1:0]  unused_sum_gen;
  logic [WIDTH:0]   result_d;

  assign armed       = (state == KEY_ARMED);
  assign key_armed_o = armed;
  assign flush       = armed & key_shift_i;
  assign adv2        = ~v2 | out_ready_i;
  assign adv1        = adv2 | ~v1;
  assign in_ready_o  = armed & ~key_shift_i & (~v1 | ~v2 | out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = v2;

  // Segment 0 never speculates; higher segments take the previous segment's generate.
  assign raw_c[0] = 1'b0;

  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    if (s < NSEG - 1) begin : g_spec
      logic [SEG_W-1:0] unused_sum;
      logic             unused_cout_spec;
      eta_segment_add #(.SEG_W(SEG_W)) u_spec (
        .a    (add1_i[s*SEG_W +: SEG_W]),
        .b    (add2_i[s*SEG_W +: SEG_W]),
        .cin  (1'b0),
        .sum  (unused_sum),
        .cout (unused_cout_spec),
        .gen  (raw_c[s+1])
      );
    end
    eta_segment_add #(.SEG_W(SEG_W)) u_sum (
      .a    (a_q[s*SEG_W +: SEG_W]),
      .b    (b_q[s*SEG_W +: SEG_W]),
      .cin  (cg_q[s]),
      .sum  (sum_raw[s*SEG_W +: SEG_W]),
      .cout (seg_cout[s]),
      .gen  (unused_sum_gen[s])
    );
  end

  assign unused_cout = seg_cout;

  // Key-gated speculative carries and key-gated sum bits.
  always_comb begin
    cg = '0;
    for (int unsigned s = 0; s < NSEG; s++) begin
      cg[s] = raw_c[s] ^ key_q[WIDTH+s] ^ KEY_CORRECT[WIDTH+s];
    end
    result_d = {seg_cout[NSEG-1], sum_raw ^ key_q[WIDTH-1:0] ^ KEY_CORRECT[WIDTH-1:0]};
  end

  // Serial key loader: every shift moves one bit in LSB-first; KEY_W shifts arm the key.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= KEY_EMPTY;
      key_q <= '0;
      cnt   <= '0;
    end else if (key_shift_i) begin
      key_q <= {key_sdi_i, key_q[KEY_W-1:1]};
      case (state)
        KEY_EMPTY, KEY_ARMED: begin
          state <= KEY_LOADING;
          cnt   <= CNT_W'(1);
        end
        KEY_LOADING: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= KEY_ARMED;
        end
        default: begin
          state <= KEY_EMPTY;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Two-stage valid/ready pipeline; a key reload discards everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cg_q     <= '0;
      result_o <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= accept;
        if (accept) begin
          a_q  <= add1_i;
          b_q  <= add2_i;
          cg_q <= cg;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) result_o <= result_d;
      end
    end
  end

`ifdef ETA_EXACT_CHECK_EN
  logic [WIDTH:0] exact_q;

  // Exact reference sum travels alongside the stage-2 result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exact_q <= '0;
    end else if (!flush && adv2 && v1) begin
      exact_q <= {1'b0, a_q} + {1'b0, b_q};
    end
  end

  assign err_o = v2 & (result_o != exact_q);

  // Saturating count of delivered results that differ from the exact sum.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (v2 && out_ready_i && err_o && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
`endif

endmodule
